// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect controller for the 5-stage pipeline: PC-update producer,
// IF/ID + ID/EX control, and saturating stall/redirect performance counters.
//
// Ports:
//   clk, rst (async, active-high)
//   id_*   : fields of the instruction in ID (pc+4, sources, beq/j, targets)
//   ex_*   : EX destination info (regwr, load, rd)
//   mem_*  : MEM load/rd and data-memory request; dmem_ready completes it
//   pc_wr, redirect, redirect_pc : PC-update interface
//   if_id_wr, if_id_flush, id_ex_bubble, pipe_freeze : pipeline control
//   stall_cycles, redirect_cnt   : performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_pc4,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_beq,
  input  logic             id_eq,
  input  logic             id_jump,
  input  logic [25:0]      id_jadr,
  input  logic [15:0]      id_boff,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memrd,
  input  logic [4:0]       mem_rd,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_wr,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             if_id_wr,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;

  logic memstall;
  logic ex_dep;
  logic mem_dep;
  logic lu;
  logic bdep;
  logic take;

  logic row_frz;
  logic row_haz;
  logic row_take;
  logic row_run;

  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;

  // ID reads r (r0 never creates a dependency)
  function automatic logic dep(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != 5'd0) &&
           ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  // ---------------------------------------------------------------
  // hazard conditions
  // ---------------------------------------------------------------
  always_comb begin
    memstall = mem_req & ~dmem_ready;
    ex_dep   = dep(ex_rd, id_rs, id_rt, id_uses_rt);
    mem_dep  = dep(mem_rd, id_rs, id_rt, id_uses_rt);
    lu       = ex_memrd & ex_dep;
    // beq compares in ID, so it waits on any EX result and on
    // loads still in MEM
    bdep     = id_beq &
               ((ex_regwr & ex_dep) | (mem_memrd & mem_dep));
    take     = (id_beq & id_eq) | id_jump;
  end

  // mutually exclusive priority rows
  always_comb begin
    row_frz  = memstall |
               ((state_q == MEM_WAIT) & ~dmem_ready);
    row_haz  = ~row_frz & (lu | bdep);
    row_take = ~row_frz & ~row_haz & take;
    row_run  = ~row_frz & ~row_haz & ~take;
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pc_wr        = 1'b0;
    redirect     = 1'b0;
    if_id_wr     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        row_frz: begin
          pipe_freeze = 1'b1;
        end
        row_haz: begin
          id_ex_bubble = 1'b1;
        end
        row_take: begin
          pc_wr       = 1'b1;
          redirect    = 1'b1;
          if_id_flush = 1'b1;
          if_id_wr    = 1'b1;
        end
        row_run: begin
          pc_wr    = 1'b1;
          if_id_wr = 1'b1;
        end
        default: begin
          pc_wr = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // redirect target (jump wins over branch)
  // ---------------------------------------------------------------
  always_comb begin
    jump_tgt = {id_pc4[31:28], id_jadr, 2'b00};
    br_tgt   = id_pc4 +
               {{14{id_boff[15]}}, id_boff, 2'b00};
    if (rst) begin
      redirect_pc = RESET_PC;
    end else if (id_jump) begin
      redirect_pc = jump_tgt;
    end else begin
      redirect_pc = br_tgt;
    end
  end

  // ---------------------------------------------------------------
  // saturating performance counters
  // ---------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if (!rst && !pc_wr && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redirect && (redir_q != '1)) begin
      redir_d = redir_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  end

  assign stall_cycles = stall_q;
  assign redirect_cnt = redir_q;

endmodule
